right_shift_unit: RTL and testbench
===================================

// Module: right_shift_unit
// PURPOSE
//   Iterative multi-cycle right shifter for the execute stage: SRL/SRA/SRLV/SRAV, and byte-address -> word-index
//   conversion (shift right 2, inverse of the branch-offset left shift).
//   Shifts up to STEP bit positions per cycle.
//   Valid/ready on both sides; the hazard unit stalls the pipeline while busy=1.
// PARAMETERS
//   WIDTH    32   data width
//   SHAMT_W  5    shift-amount width, = $clog2(WIDTH)
//   STEP     4    max bit positions shifted per cycle; power of two, 1..WIDTH
// PORTS
//   clk        in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   flush      in   1        pipeline flush: abandon in-flight op
//   in_valid   in   1        request valid
//   in_ready   out  1        unit can accept (1 only in IDLE)
//   in_data    in   WIDTH    operand to shift
//   in_shamt   in   SHAMT_W  shift amount 0..WIDTH-1
//   in_arith   in   1        1 = arithmetic (sign fill), 0 = logical (zero fill)
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result
//   out_data   out  WIDTH    shifted result
//   busy       out  1        1 in SHIFT or DONE
// BEHAVIOUR
//   - Reset (sync, priority over everything): state=IDLE, out_valid=0, out_data=0, busy=0, in_ready=1;
//     internal acc/remaining/arith cleared.
//   - flush (below reset): same state effect as reset; out_data keeps its value; any pending result is dropped.
//   - States:
//     IDLE  : in_ready=1. On in_valid: load acc=in_data, rem=in_shamt, arith=in_arith.
//             Go to DONE if in_shamt==0, else SHIFT.
//     SHIFT : s = min(rem, STEP); acc = acc >> s, vacated MSBs filled with acc[WIDTH-1] if arith, else 0;
//             rem -= s; go to DONE when rem-s==0.
//     DONE  : out_valid=1, out_data=acc held stable; on out_ready go to IDLE.
//   - Latency: handshake accepted at edge T -> out_valid high from edge T+1+ceil(shamt/STEP).
//     shamt=0 -> T+1; shamt=31, STEP=4 -> T+9.
//   - No accept in the cycle a result is consumed: the earliest next accept is the cycle after out_ready.
//   - out_ready held low: stay in DONE indefinitely; out_data must not change.
//   - in_valid while busy: ignored, no capture; in_data may change freely.
//   - Inputs are sampled only at the accept edge; later changes have no effect.
//   - Arithmetic fill uses the ORIGINAL sign bit; that bit is preserved because it is replicated each step.
//   - The result equals a single-cycle shift: logical = in_data >> shamt; arithmetic = $signed(in_data) >>> shamt.
//   - flush and in_valid in the same IDLE cycle: flush wins, nothing is accepted.
//   - flush and out_ready in the same DONE cycle: go to IDLE; the consumer must discard the result.
// STRUCTURE
//   - shift_pkg: state enum {IDLE, SHIFT, DONE} (2-bit); constants SHIFT_LOGICAL=1'b0, SHIFT_ARITH=1'b1;
//     default WIDTH/STEP values.
//   - Sub-module rshift_step: combinational shift of (data, amt 0..STEP, fill_bit) -> data; one instance.
//   - Top level holds the FSM, acc/rem/arith registers and handshake logic.
// TESTING
//   - SRL 0x80000000 by 4, STEP=4, out_ready=1
//     -> out_data=0x08000000, out_valid 2 cycles after accept, held 1 cycle.
//   - SRA 0x80000000 by 31 -> 0xFFFFFFFF, latency 9; SRA 0x7FFFFFF0 by 4 -> 0x07FFFFFF.
//   - Word index: SRL 0x00400010 by 2 -> 0x00100004; shamt=0 on 0xDEADBEEF -> 0xDEADBEEF, latency 1.
//   - Backpressure: out_ready low 5 cycles in DONE -> out_valid and out_data stable;
//     in_valid during that time is not accepted.
//   - reset asserted in the 3rd SHIFT cycle of SRA 0x80000000 by 20 -> next edge state=IDLE, out_valid=0,
//     in_ready=1; a new request then completes correctly.
//   - flush mid-SHIFT -> no out_valid pulse; back-to-back random ops (1000, both modes, STEP 1/4/32)
//     match the reference shift expression.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative right shifter.
package shift_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic SHIFT_LOGICAL = 1'b0;
   localparam logic SHIFT_ARITH   = 1'b1;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_STEP  = 4;

endpackage

// File: rtl/rshift_step.sv
// One combinational right-shift step of 0..STEP positions with a selectable fill bit.
module rshift_step #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 3
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic [AMT_W-1:0] i_amt,
   input  logic             i_fill,
   output logic [WIDTH-1:0] o_data
);

   // Logical shift, then OR the fill bit into the vacated upper positions.
   always_comb begin
      o_data = (i_data >> i_amt) | ({WIDTH{i_fill}} & ~({WIDTH{1'b1}} >> i_amt));
   end

endmodule

// File: rtl/right_shift_unit.sv
// Iterative multi-cycle right shifter (logical/arithmetic), up to STEP bits per cycle,
// valid/ready on both sides and a busy flag for the hazard unit.
module right_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int SHAMT_W = $clog2(WIDTH),
   parameter int STEP    = DEFAULT_STEP
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic               in_arith,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               busy
);

   // Wide enough to hold any per-cycle amount 0..STEP.
   localparam int AMT_W = $clog2(STEP + 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_acc;
   logic [SHAMT_W-1:0] r_rem;
   logic               r_arith;
   logic [WIDTH-1:0]   r_out_data;

   logic [AMT_W-1:0]   w_amt;
   logic [SHAMT_W-1:0] w_rem_next;
   logic               w_fill;
   logic [WIDTH-1:0]   w_shifted;

   // Per-cycle amount is min(remaining, STEP); the fill bit is the current MSB, which
   // stays equal to the original sign bit because every step replicates it.
   always_comb begin
      if (int'(r_rem) < STEP) begin
         w_amt = AMT_W'(r_rem);
      end else begin
         w_amt = AMT_W'(STEP);
      end
      w_rem_next = r_rem - SHAMT_W'(w_amt);
      w_fill     = (r_arith == SHIFT_ARITH) & r_acc[WIDTH-1];
   end

   rshift_step #(
      .WIDTH (WIDTH),
      .AMT_W (AMT_W)
   ) u_step (
      .i_data (r_acc),
      .i_amt  (w_amt),
      .i_fill (w_fill),
      .o_data (w_shifted)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; flush abandons whatever is in flight.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (in_valid) begin
               w_state_next = (in_shamt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            if (w_rem_next == '0) begin
               w_state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
      if (flush) begin
         w_state_next = IDLE;
      end
   end

   // Outputs decoded from the state; the result register is held for the whole DONE stay.
   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == DONE);
      busy      = (r_state != IDLE);
      out_data  = r_out_data;
   end

   // Datapath: capture on accept, shift while in SHIFT, latch the result on entry to DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc      <= '0;
         r_rem      <= '0;
         r_arith    <= SHIFT_LOGICAL;
         r_out_data <= '0;
      end else if (flush) begin
         r_acc   <= '0;
         r_rem   <= '0;
         r_arith <= SHIFT_LOGICAL;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_acc   <= in_data;
                  r_rem   <= in_shamt;
                  r_arith <= in_arith;
                  if (in_shamt == '0) begin
                     r_out_data <= in_data;
                  end
               end
            end
            SHIFT: begin
               r_acc <= w_shifted;
               r_rem <= w_rem_next;
               if (w_rem_next == '0) begin
                  r_out_data <= w_shifted;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_right_shift_unit.sv
// Bench for right_shift_unit: three instances (STEP 1, 4, 32) checked every cycle against
// a cycle-count/reference-shift model, plus directed cases with literal expectations.
module tb_right_shift_unit;

   localparam int W = 32;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          flush;
   logic          in_valid  [N];
   logic          in_ready  [N];
   logic [W-1:0]  in_data   [N];
   logic [4:0]    in_shamt  [N];
   logic          in_arith  [N];
   logic          out_valid [N];
   logic          out_ready [N];
   logic [W-1:0]  out_data  [N];
   logic          busy      [N];

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   function automatic int step_of(input int k);
      return (k == 0) ? 1 : ((k == 1) ? 4 : 32);
   endfunction

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_dut
         right_shift_unit #(
            .WIDTH   (W),
            .SHAMT_W (5),
            .STEP    ((gi == 0) ? 1 : ((gi == 1) ? 4 : 32))
         ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid[gi]),
            .in_ready  (in_ready[gi]),
            .in_data   (in_data[gi]),
            .in_shamt  (in_shamt[gi]),
            .in_arith  (in_arith[gi]),
            .out_valid (out_valid[gi]),
            .out_ready (out_ready[gi]),
            .out_data  (out_data[gi]),
            .busy      (busy[gi])
         );
      end
   endgenerate

   // Reference result: the single-cycle shift expression.
   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [4:0] sh,
                                              input logic ar);
      logic signed [W-1:0] sd;
      sd = d;
      if (ar) return sd >>> sh;
      return d >> sh;
   endfunction

   task automatic check(input string nm, input int k, input logic [W-1:0] act,
                        input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
      end
   endtask

   // Behavioural model: 0 = waiting for work, 1 = computing (m_cnt cycles left),
   // 2 = result presented. Result and latency come from the reference expression.
   int           m_state [N];
   int           m_cnt   [N];
   logic [W-1:0] m_res   [N];
   logic [W-1:0] m_odata [N];

   always @(posedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (reset) begin
            m_state[k] <= 0;
            m_odata[k] <= '0;
         end else if (flush) begin
            m_state[k] <= 0;
         end else begin
            case (m_state[k])
               0: begin
                  if (in_valid[k]) begin
                     automatic int cnt = (int'(in_shamt[k]) + step_of(k) - 1) / step_of(k);
                     automatic logic [W-1:0] r = ref_shift(in_data[k], in_shamt[k], in_arith[k]);
                     m_res[k] <= r;
                     m_cnt[k] <= cnt;
                     if (cnt == 0) begin
                        m_state[k] <= 2;
                        m_odata[k] <= r;
                     end else begin
                        m_state[k] <= 1;
                     end
                  end
               end
               1: begin
                  m_cnt[k] <= m_cnt[k] - 1;
                  if (m_cnt[k] == 1) begin
                     m_state[k] <= 2;
                     m_odata[k] <= m_res[k];
                  end
               end
               default: begin
                  if (out_ready[k]) m_state[k] <= 0;
               end
            endcase
         end
      end
   end

   // Compare every output of every instance against the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < N; k++) begin
            check("in_ready",  k, W'(in_ready[k]),  W'(m_state[k] == 0));
            check("busy",      k, W'(busy[k]),      W'(m_state[k] != 0));
            check("out_valid", k, W'(out_valid[k]), W'(m_state[k] == 2));
            check("out_data",  k, out_data[k],      m_odata[k]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction: offer, wait for result, optionally backpressure (and poke in_valid), consume.
   task automatic run_op(input int k, input logic [W-1:0] d, input logic [4:0] sh,
                         input logic ar, input int hold, input bit poke,
                         output logic [W-1:0] res, output int lat);
      int n;
      n = 0;
      in_data[k]   = d;
      in_shamt[k]  = sh;
      in_arith[k]  = ar;
      in_valid[k]  = 1'b1;
      out_ready[k] = 1'b0;
      while (!in_ready[k] && n < 64) begin
         tick();
         n++;
      end
      check("accept", k, W'(in_ready[k]), W'(1'b1));
      tick();
      in_valid[k] = 1'b0;
      in_data[k]  = $urandom;
      in_shamt[k] = 5'($urandom_range(0, 31));
      in_arith[k] = ~ar;
      lat = 1;
      while (!out_valid[k] && lat < 100) begin
         tick();
         lat++;
      end
      check("valid_seen", k, W'(out_valid[k]), W'(1'b1));
      res = out_data[k];
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid[k] = 1'b1;
            in_data[k]  = $urandom;
            in_shamt[k] = 5'($urandom_range(0, 31));
         end
         tick();
         check("hold_valid", k, W'(out_valid[k]), W'(1'b1));
         check("hold_data",  k, out_data[k], res);
         check("hold_ready", k, W'(in_ready[k]), W'(1'b0));
      end
      out_ready[k] = 1'b1;
      tick();
      out_ready[k] = 1'b0;
      in_valid[k]  = 1'b0;
      check("consumed", k, W'(out_valid[k]), W'(1'b0));
      $display("op k=%0d step=%0d %s data=%h shamt=%0d -> %h latency %0d",
               k, step_of(k), ar ? "SRA" : "SRL", d, sh, res, lat);
   endtask

   initial begin
      logic [W-1:0] res;
      int           lat;

      reset = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < N; k++) begin
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         in_shamt[k]  = '0;
         in_arith[k]  = 1'b0;
         out_ready[k] = 1'b0;
      end
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_out_data",  1, out_data[1], 32'h0);
      check("rst_out_valid", 1, W'(out_valid[1]), W'(1'b0));
      check("rst_in_ready",  1, W'(in_ready[1]), W'(1'b1));
      check("rst_busy",      1, W'(busy[1]), W'(1'b0));
      reset = 1'b0;
      tick();

      // Directed cases on the STEP=4 instance.
      run_op(1, 32'h8000_0000, 5'd4, 1'b0, 0, 1'b0, res, lat);
      check("srl4_data", 1, res, 32'h0800_0000);
      check("srl4_lat",  1, W'(lat), W'(2));

      run_op(1, 32'h8000_0000, 5'd31, 1'b1, 0, 1'b0, res, lat);
      check("sra31_data", 1, res, 32'hFFFF_FFFF);
      check("sra31_lat",  1, W'(lat), W'(9));

      run_op(1, 32'h7FFF_FFF0, 5'd4, 1'b1, 0, 1'b0, res, lat);
      check("sra4_pos_data", 1, res, 32'h07FF_FFFF);

      run_op(1, 32'h0040_0010, 5'd2, 1'b0, 0, 1'b0, res, lat);
      check("word_idx_data", 1, res, 32'h0010_0004);

      run_op(1, 32'hDEAD_BEEF, 5'd0, 1'b0, 0, 1'b0, res, lat);
      check("sh0_data", 1, res, 32'hDEAD_BEEF);
      check("sh0_lat",  1, W'(lat), W'(1));

      run_op(1, 32'h1234_5678, 5'd8, 1'b0, 5, 1'b1, res, lat);
      check("bp_data", 1, res, 32'h0012_3456);

      // Reset in the third SHIFT cycle of SRA 0x80000000 by 20.
      in_data[1] = 32'h8000_0000; in_shamt[1] = 5'd20; in_arith[1] = 1'b1; in_valid[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("mid_rst_ready", 1, W'(in_ready[1]), W'(1'b1));
      check("mid_rst_valid", 1, W'(out_valid[1]), W'(1'b0));
      reset = 1'b0;
      run_op(1, 32'h8000_0000, 5'd20, 1'b1, 0, 1'b0, res, lat);
      check("after_rst_data", 1, res, 32'hFFFF_F800);
      check("after_rst_lat",  1, W'(lat), W'(6));

      // Flush mid-SHIFT: no result may appear.
      in_data[1] = 32'hF000_0000; in_shamt[1] = 5'd28; in_arith[1] = 1'b0; in_valid[1] = 1'b1;
      tick();
      in_valid[1] = 1'b0;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_ready", 1, W'(in_ready[1]), W'(1'b1));
      for (int i = 0; i < 12; i++) begin
         tick();
         check("flush_no_valid", 1, W'(out_valid[1]), W'(1'b0));
      end

      // Flush together with in_valid in IDLE: nothing accepted.
      in_data[1] = 32'hCAFE_0000; in_shamt[1] = 5'd0; in_valid[1] = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      in_valid[1] = 1'b0;
      check("flush_accept_ready", 1, W'(in_ready[1]), W'(1'b1));
      tick();
      check("flush_accept_valid", 1, W'(out_valid[1]), W'(1'b0));

      // Randomized back-to-back traffic on all three step sizes.
      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < 334; i++) begin
            automatic logic [W-1:0] d  = $urandom;
            automatic logic [4:0]   sh = 5'($urandom_range(0, 31));
            automatic logic         ar = 1'($urandom_range(0, 1));
            automatic int           hd = $urandom_range(0, 2);
            run_op(k, d, sh, ar, hd, 1'($urandom_range(0, 1)), res, lat);
            check("rand_data", k, res, ref_shift(d, sh, ar));
            check("rand_lat",  k, W'(lat), W'(1 + (int'(sh) + step_of(k) - 1) / step_of(k)));
         end
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
